sa_tile_writer: RTL
===================

# sa_tile_writer

Parametrised successor to the fixed 16-row systolic-array tile writer. It accepts systolic-array output rows over a valid/ready handshake and writes them into one of `NUM_BANKS` ping-pong BRAM banks. Addresses come from a runtime base and stride. Banks are tracked full/free so that a downstream reader (attention/softmax stage) can drain one bank while the next tile fills another. It sits between the systolic array output and the Q/K/V buffer banks.

## Interface
Parameters:
- `DATA_W`, 256, row width in bits (one SA output row)
- `ADDR_W`, 16, BRAM address width
- `MAX_ROWS`, 16, maximum rows per tile; `ROWS_W = $clog2(MAX_ROWS+1)`
- `NUM_BANKS`, 2, number of BRAM banks (≥2); `BANK_W = max(1,$clog2(NUM_BANKS))`

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  one-cycle request to write a new tile
- `abort`  in  1  cancel the tile in progress
- `cfg_base`  in  ADDR_W  first row address of the tile
- `cfg_stride`  in  ADDR_W  address increment per row
- `cfg_rows`  in  ROWS_W  rows in the tile; 0 means MAX_ROWS
- `in_valid`  in  1  SA row valid
- `in_data`  in  DATA_W  SA row data
- `in_ready`  out  1  writer accepts a row
- `bram_en`  out  NUM_BANKS  one-hot port-A enable per bank
- `bram_we`  out  1  port-A write enable
- `bram_addr`  out  ADDR_W  port-A address
- `bram_din`  out  DATA_W  port-A write data
- `bank_release`  in  NUM_BANKS  reader frees bank b (pulse)
- `bank_full`  out  NUM_BANKS  bank holds a complete unread tile
- `wr_bank`  out  BANK_W  bank targeted by the current or next tile
- `busy`  out  1  state ≠ IDLE
- `write_done`  out  1  one-cycle pulse on the final row write
- `tile_count`  out  16  tiles completed since reset, wraps at 2^16

## Operation
- States: IDLE, WAIT_BANK, WRITE.
- IDLE + `start`:
  - latch `cfg_base`, `cfg_stride` and rows (0→MAX_ROWS) into internal registers;
  - load the address register with `cfg_base`;
  - go to WAIT_BANK if `bank_full[wr_bank]`, else WRITE.
- `start` outside IDLE is ignored. Config inputs are sampled only at an accepted `start`.
- WAIT_BANK: go to WRITE in the cycle after `bank_full[wr_bank]` is seen low.
- WRITE:
  - `in_ready = 1`;
  - each handshake (`in_valid & in_ready`) issues one write of `in_data` at the current address, then `addr ← addr + stride` modulo 2^ADDR_W (wrap, no error);
  - row counter increments per handshake.
- Final handshake (row count reaches the latched row count):
  - set `bank_full[wr_bank]`;
  - `wr_bank ← (wr_bank+1) mod NUM_BANKS`;
  - `tile_count++`;
  - return to IDLE.
- `abort` (any state, highest priority):
  - go to IDLE;
  - no further writes are issued, except a write already registered, which completes;
  - `bank_full` is not set, `wr_bank` and `tile_count` are unchanged, `write_done` is not pulsed.
- `bank_release[b]` clears `bank_full[b]`. Release of a non-full bank has no effect. If set and release hit the same bank in the same cycle, set wins.
- Reset: all outputs 0 (`in_ready`, `bram_en`, `bram_we`, `bram_addr`, `bram_din`, `bank_full`, `wr_bank`, `busy`, `write_done`, `tile_count`). State is IDLE. Asserting reset mid-tile discards the tile.

## Timing
- `start` at cycle t with bank free: WRITE and `in_ready = 1` from t+1.
- With bank full: `in_ready = 1` from the cycle after release is observed (release at r → `bank_full` low at r+1 → `in_ready` at r+2).
- BRAM outputs are registered:
  - handshake at cycle k → `bram_we = 1`, the `bram_en` one-hot, `bram_addr` and `bram_din` valid during k+1;
  - idle cycles give `bram_we = 0` and `bram_en = 0`, with addr/din held.
- Final handshake at k:
  - `write_done = 1`, `bank_full` set and `wr_bank` advanced, all visible at k+1;
  - `in_ready = 0` from k+1;
  - a new `start` is accepted at k+1 at the earliest.
- Throughput is one row per cycle while `in_valid` is held high. Gaps in `in_valid` stall without losing address state.

## Test plan
- Basic tile: base=0x0000, stride=23, rows=16, `in_valid` held → 16 writes at 0,23,…,345 in bank 0; `write_done` pulses with the 16th write; `bank_full = 01`; `wr_bank = 1`; `tile_count = 1`.
- Ping-pong with backpressure (NUM_BANKS=2):
  - three back-to-back tiles with no release → tile 3 sits in WAIT_BANK with `in_ready = 0`;
  - `bank_release[0]` pulse → `in_ready` rises two cycles later and bank 0 is written.
- Address wrap and rows=0: base=0xFFF0, stride=8, rows=0 → 16 writes at 0xFFF0, 0xFFF8, 0x0000, … (mod 2^16).
- Stalled input: `in_valid` toggling 1010…, rows=4 → exactly 4 writes with consecutive strided addresses; `write_done` with the 4th write.
- Abort and reset: `abort` after 5 rows → IDLE, `bank_full` unchanged, `tile_count` unchanged; the next tile restarts at the new `cfg_base` in the same bank. `rst` mid-tile → all outputs 0 immediately.
- Set/release collision: release bank 1 in the same cycle it completes → `bank_full[1] = 1`.

Source files
------------

// File: rtl/sa_tile_writer.sv
// sa_tile_writer: accepts systolic-array output rows over valid/ready and
// writes them into one of NUM_BANKS ping-pong BRAM banks at base + n*stride.
// Each bank is marked full when a tile completes and freed by the reader.
module sa_tile_writer #(
  parameter  int DATA_W    = 256,
  parameter  int ADDR_W    = 16,
  parameter  int MAX_ROWS  = 16,
  parameter  int NUM_BANKS = 2,
  localparam int ROWS_W    = $clog2(MAX_ROWS + 1),
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [ADDR_W-1:0]    cfg_stride,
  input  logic [ROWS_W-1:0]    cfg_rows,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [NUM_BANKS-1:0] bram_en,
  output logic                 bram_we,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [DATA_W-1:0]    bram_din,
  input  logic [NUM_BANKS-1:0] bank_release,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic [BANK_W-1:0]    wr_bank,
  output logic                 busy,
  output logic                 write_done,
  output logic [15:0]          tile_count
);

  typedef enum logic [1:0] {IDLE, WAIT_BANK, WRITE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    stride_q, stride_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ROWS_W-1:0]    rows_q, rows_d;
  logic [ROWS_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [15:0]          tiles_q, tiles_d;
  logic [NUM_BANKS-1:0] en_q, en_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    baddr_q, baddr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic                 done_q, done_d;

  logic                 fire;
  logic                 last;
  logic [NUM_BANKS-1:0] bank_onehot;
  logic [NUM_BANKS-1:0] set_mask;
  logic [BANK_W-1:0]    bank_next;

  // Abort suppresses acceptance in the same cycle so no row is taken and dropped.
  assign in_ready    = (state_q == WRITE) && !abort;
  assign fire        = in_valid && in_ready;
  assign last        = fire && ((cnt_q + ROWS_W'(1)) == rows_q);
  assign bank_onehot = NUM_BANKS'(1) << bank_q;
  assign bank_next   = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + BANK_W'(1);

  // Next-state logic: FSM transitions, address/row tracking, registered BRAM port.
  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    addr_d   = addr_q;
    rows_d   = rows_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    tiles_d  = tiles_q;
    en_d     = '0;
    we_d     = 1'b0;
    baddr_d  = baddr_q;
    din_d    = din_q;
    done_d   = 1'b0;
    set_mask = '0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          stride_d = cfg_stride;
          addr_d   = cfg_base;
          rows_d   = (cfg_rows == '0) ? ROWS_W'(MAX_ROWS) : cfg_rows;
          cnt_d    = '0;
          state_d  = full_q[bank_q] ? WAIT_BANK : WRITE;
        end
      end
      WAIT_BANK: begin
        if (!full_q[bank_q]) state_d = WRITE;
      end
      WRITE: begin
        if (fire) begin
          en_d    = bank_onehot;
          we_d    = 1'b1;
          baddr_d = addr_q;
          din_d   = in_data;
          addr_d  = addr_q + stride_q;
          cnt_d   = cnt_q + ROWS_W'(1);
          if (last) begin
            set_mask = bank_onehot;
            bank_d   = bank_next;
            tiles_d  = tiles_q + 16'd1;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;

    // A completing tile wins over a release of the same bank.
    full_d = (full_q & ~bank_release) | set_mask;
  end

  // State and datapath registers; reset clears every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      stride_q <= '0;
      addr_q   <= '0;
      rows_q   <= '0;
      cnt_q    <= '0;
      full_q   <= '0;
      bank_q   <= '0;
      tiles_q  <= '0;
      en_q     <= '0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      din_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      rows_q   <= rows_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      bank_q   <= bank_d;
      tiles_q  <= tiles_d;
      en_q     <= en_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      din_q    <= din_d;
      done_q   <= done_d;
    end
  end

  assign bram_en    = en_q;
  assign bram_we    = we_q;
  assign bram_addr  = baddr_q;
  assign bram_din   = din_q;
  assign bank_full  = full_q;
  assign wr_bank    = bank_q;
  assign busy       = (state_q != IDLE);
  assign write_done = done_q;
  assign tile_count = tiles_q;

endmodule
